exe_stage: RTL and testbench

- Execute stage of the 5-stage ARM pipeline. It consumes the ID/EX register outputs and performs operand forwarding selection, Val2 (shifter operand) generation, the ALU operation and branch-target computation.
- It holds the architectural NZCV status register, which is fed back to ID.
- Results are registered into an integrated EX/MEM pipeline register that feeds the MEM stage.

---
 rtl/arm_pkg.sv | 43 ++++
 rtl/exe_stage_if.sv | 34 +++
 rtl/val2_gen.sv | 27 ++
 rtl/exe_stage.sv | 87 ++++++++
 tb/tb_exe_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU commands, shifter types, forwarding selects, SR layout.
// Also the right-rotate helper used by the shifter operand logic.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
        return 32'({x, x} >> amt);
    endfunction

    // Select 11 falls back to the register file value.
    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] mem_v, input logic [31:0] wb_v);
        case (sel)
            FWD_MEM: return mem_v;
            FWD_WB:  return wb_v;
            default: return rf;
        endcase
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled for a single port.
interface exe_stage_if;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] mem_fwd_val, wb_fwd_val;

    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_res, st_val;
    logic [3:0]  dest;

    modport slave (
        input  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in,
               pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in, dest_in,
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        output branch_taken, branch_addr, status, wb_en, mem_r_en, mem_w_en,
               alu_res, st_val, dest
    );

    modport master (
        output wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in,
               pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in, dest_in,
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        input  branch_taken, branch_addr, status, wb_en, mem_r_en, mem_w_en,
               alu_res, st_val, dest
    );
endinterface

// File: rtl/val2_gen.sv
// Shifter operand: load/store offset, rotated 8-bit immediate, or shifted Rm.
// Purely combinational; a zero shift amount passes Rm through for every shift type.
module val2_gen
    import arm_pkg::*;
(
    input  logic [31:0] rm,
    input  logic [11:0] shift_op,
    input  logic        imm,
    input  logic        mem_en,
    output logic [31:0] val2
);
    always_comb begin
        val2 = rm;
        if (mem_en) begin
            val2 = {20'b0, shift_op};
        end else if (imm) begin
            val2 = ror32({24'b0, shift_op[7:0]}, {shift_op[11:8], 1'b0});
        end else begin
            case (shift_op[6:5])
                SH_LSL:  val2 = rm << shift_op[11:7];
                SH_LSR:  val2 = rm >> shift_op[11:7];
                SH_ASR:  val2 = $signed(rm) >>> shift_op[11:7];
                default: val2 = ror32(rm, shift_op[11:7]);
            endcase
        end
    end
endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, shifter operand, ALU, NZCV register and EX/MEM register.
// One cycle to EX/MEM outputs; branch_taken/branch_addr are same-cycle. freeze holds EX/MEM and SR.
module exe_stage
    import arm_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    exe_stage_if.slave    bus
);
    logic [DW-1:0] op1, fwd_rm, val2, res;
    logic [DW:0]   sum;
    logic          n_new, z_new, c_new, v_new, known;

    assign op1    = fwd_sel(bus.sel_src1, bus.val_rn_in, bus.mem_fwd_val, bus.wb_fwd_val);
    assign fwd_rm = fwd_sel(bus.sel_src2, bus.val_rm_in, bus.mem_fwd_val, bus.wb_fwd_val);

    val2_gen u_val2_gen (
        .rm       (fwd_rm),
        .shift_op (bus.shift_operand_in),
        .imm      (bus.imm_in),
        .mem_en   (bus.mem_r_en_in | bus.mem_w_en_in),
        .val2     (val2)
    );

    assign bus.branch_taken = bus.b_in;
    assign bus.branch_addr  = bus.pc_in + {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};

    // Subtraction is op1 + ~val2 + carry-in, so the carry-out is directly NOT borrow.
    always_comb begin
        res   = '0;
        sum   = '0;
        known = 1'b1;
        n_new = bus.status[SR_N];
        z_new = bus.status[SR_Z];
        c_new = bus.status[SR_C];
        v_new = bus.status[SR_V];
        case (bus.exe_cmd_in)
            EXE_MOV: res = val2;
            EXE_MVN: res = ~val2;
            EXE_ADD, EXE_ADC: begin
                sum   = {1'b0, op1} + {1'b0, val2}
                      + {{DW{1'b0}}, (bus.exe_cmd_in == EXE_ADC) & bus.status[SR_C]};
                res   = sum[DW-1:0];
                c_new = sum[DW];
                v_new = (op1[DW-1] == val2[DW-1]) && (res[DW-1] != op1[DW-1]);
            end
            EXE_SUB, EXE_SBC: begin
                sum   = {1'b0, op1} + {1'b0, ~val2}
                      + {{DW{1'b0}}, (bus.exe_cmd_in == EXE_SUB) | bus.status[SR_C]};
                res   = sum[DW-1:0];
                c_new = sum[DW];
                v_new = (op1[DW-1] != val2[DW-1]) && (res[DW-1] != op1[DW-1]);
            end
            EXE_AND: res = op1 & val2;
            EXE_ORR: res = op1 | val2;
            EXE_EOR: res = op1 ^ val2;
            default: known = 1'b0;
        endcase
        if (known) begin
            n_new = res[DW-1];
            z_new = (res == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_en    <= 1'b0;
            bus.mem_r_en <= 1'b0;
            bus.mem_w_en <= 1'b0;
            bus.alu_res  <= '0;
            bus.st_val   <= '0;
            bus.dest     <= 4'hF;
            bus.status   <= 4'b0000;
        end else if (!freeze) begin
            bus.wb_en    <= bus.wb_en_in;
            bus.mem_r_en <= bus.mem_r_en_in;
            bus.mem_w_en <= bus.mem_w_en_in;
            bus.alu_res  <= res;
            bus.st_val   <= fwd_rm;
            bus.dest     <= bus.dest_in;
            if (bus.s_in) bus.status <= {n_new, z_new, c_new, v_new};
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Randomised and directed bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;
    logic clk = 1'b0;
    logic rst;
    logic freeze;
    exe_stage_if bus ();

    exe_stage #(.DW(32)) dut (.clk(clk), .rst(rst), .freeze(freeze), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic [3:0]  m_sr;
    logic        exp_wb, exp_mr, exp_mw, exp_bt;
    logic [31:0] exp_res, exp_st, exp_ba;
    logic [3:0]  exp_dest, exp_status;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return w;
        return r;
    endfunction

    function automatic logic [31:0] m_rotr(input logic [31:0] v, input int a);
        longint unsigned x;
        x = 64'(v);
        if (a == 0) return v;
        return 32'((x >> a) | (x << (32 - a)));
    endfunction

    function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] so,
                                           input logic imm, input logic mem);
        longint unsigned x;
        longint          s;
        int              a;
        x = 64'(rm);
        s = longint'($signed(rm));
        a = {27'b0, so[11:7]};
        if (mem) return {20'b0, so};
        if (imm) return m_rotr({24'b0, so[7:0]}, 2 * {28'b0, so[11:8]});
        case (so[6:5])
            2'd0:    return 32'(x << a);
            2'd1:    return 32'(x >> a);
            2'd2:    return 32'(s >>> a);
            default: return m_rotr(rm, a);
        endcase
    endfunction

    // Returns {new NZCV, result}; unknown commands give result 0 and the old flags.
    function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] sr);
        longint unsigned ua, ub, cy, u;
        longint          sa, sb, sres;
        logic [31:0]     res;
        logic            c, v;
        ua = 64'(a); ub = 64'(b); cy = 64'(sr[1]);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        c = sr[1]; v = sr[0]; res = 32'd0;
        case (cmd)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd2, 4'd3: begin
                if (cmd == 4'd2) cy = 0;
                u = ua + ub + cy;
                res = u[31:0];
                c = (u >> 32) != 0;
                sres = sa + sb + longint'(cy);
                v = (sres > SMAX) || (sres < SMIN);
            end
            4'd4, 4'd5: begin
                if (cmd == 4'd4) cy = 1;
                res = 32'(ua - ub - (1 - cy));
                c = ua >= ub + (1 - cy);
                sres = sa - sb - longint'(1 - cy);
                v = (sres > SMAX) || (sres < SMIN);
            end
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            default: return {sr, 32'd0};
        endcase
        return {res[31], res == 32'd0, c, v, res};
    endfunction

    task automatic model_step();
        logic [31:0] a, rm, v2;
        logic [35:0] r;
        exp_bt = bus.b_in;
        exp_ba = 32'(longint'(bus.pc_in) + longint'($signed(bus.signed_imm_24_in)) * 4);
        if (rst) begin
            exp_wb = 0; exp_mr = 0; exp_mw = 0; exp_res = 0; exp_st = 0;
            exp_dest = 4'hF; m_sr = 4'b0000;
        end else if (!freeze) begin
            a  = m_fwd(bus.sel_src1, bus.val_rn_in, bus.mem_fwd_val, bus.wb_fwd_val);
            rm = m_fwd(bus.sel_src2, bus.val_rm_in, bus.mem_fwd_val, bus.wb_fwd_val);
            v2 = m_val2(rm, bus.shift_operand_in, bus.imm_in, bus.mem_r_en_in | bus.mem_w_en_in);
            r  = m_alu(bus.exe_cmd_in, a, v2, m_sr);
            exp_res = r[31:0]; exp_st = rm; exp_dest = bus.dest_in;
            exp_wb = bus.wb_en_in; exp_mr = bus.mem_r_en_in; exp_mw = bus.mem_w_en_in;
            if (bus.s_in) m_sr = r[35:32];
        end
        exp_status = m_sr;
    endtask

    always @(posedge clk) begin
        if (armed) begin
            #1;
            chk("wb_en", 32'(bus.wb_en), 32'(exp_wb));
            chk("mem_r_en", 32'(bus.mem_r_en), 32'(exp_mr));
            chk("mem_w_en", 32'(bus.mem_w_en), 32'(exp_mw));
            chk("alu_res", bus.alu_res, exp_res);
            chk("st_val", bus.st_val, exp_st);
            chk("dest", 32'(bus.dest), 32'(exp_dest));
            chk("status", 32'(bus.status), 32'(exp_status));
            chk("branch_taken", 32'(bus.branch_taken), 32'(exp_bt));
            chk("branch_addr", bus.branch_addr, exp_ba);
        end
    end

    task automatic go();
        model_step();
        armed = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        rst = 0; freeze = 0;
        bus.wb_en_in = 0; bus.mem_r_en_in = 0; bus.mem_w_en_in = 0;
        bus.b_in = 0; bus.s_in = 0; bus.imm_in = 0; bus.exe_cmd_in = 4'd0;
        bus.pc_in = 0; bus.val_rn_in = 0; bus.val_rm_in = 0; bus.shift_operand_in = 12'd0;
        bus.signed_imm_24_in = 24'd0; bus.dest_in = 4'd0; bus.sel_src1 = 2'd0; bus.sel_src2 = 2'd0;
        bus.mem_fwd_val = 0; bus.wb_fwd_val = 0;
    endtask

    task automatic sub55();
        clr(); bus.exe_cmd_in = 4'd4; bus.val_rn_in = 5; bus.val_rm_in = 5;
        bus.s_in = 1; bus.wb_en_in = 1; bus.dest_in = 4'd3;
    endtask

    task automatic add_ovf(input logic s);
        clr(); bus.exe_cmd_in = 4'd2; bus.val_rn_in = 32'h7FFFFFFF; bus.val_rm_in = 1;
        bus.s_in = s; bus.dest_in = 4'd5;
    endtask

    initial begin
        clr(); rst = 1;
        go(); go();
        chk("rst_dest", 32'(bus.dest), 32'hF);
        chk("rst_status", 32'(bus.status), 32'h0);
        chk("rst_alu", bus.alu_res, 32'h0);

        // 0xFF rotated right by 4 is 0xF000000F; plus 1.
        clr(); bus.imm_in = 1; bus.shift_operand_in = 12'h2FF; bus.val_rn_in = 1;
        bus.exe_cmd_in = 4'd2; bus.s_in = 1; go();
        chk("imm_add", bus.alu_res, 32'hF0000010);
        chk("imm_add_sr", 32'(bus.status), 32'h8);

        sub55(); go();
        chk("sub_res", bus.alu_res, 32'h0);
        chk("sub_sr", 32'(bus.status), 32'h6);
        clr(); bus.exe_cmd_in = 4'd3; bus.val_rn_in = 1; bus.val_rm_in = 1; go();
        chk("adc_res", bus.alu_res, 32'h3);

        add_ovf(1); go();
        chk("ovf_res", bus.alu_res, 32'h80000000);
        chk("ovf_sr", 32'(bus.status), 32'h9);
        sub55(); go();
        add_ovf(0); go();
        chk("no_s_sr", 32'(bus.status), 32'h6);

        clr(); bus.sel_src1 = 2'd1; bus.mem_fwd_val = 10; bus.sel_src2 = 2'd2;
        bus.wb_fwd_val = 32'h80000000; bus.shift_operand_in = 12'h0C0; bus.exe_cmd_in = 4'd1; go();
        chk("asr_mov", bus.alu_res, 32'hC0000000);
        chk("asr_st", bus.st_val, 32'h80000000);
        clr(); bus.sel_src1 = 2'd1; bus.mem_fwd_val = 10; bus.sel_src2 = 2'd2;
        bus.wb_fwd_val = 7; bus.mem_w_en_in = 1; bus.shift_operand_in = 12'h004;
        bus.exe_cmd_in = 4'd2; go();
        chk("str_addr", bus.alu_res, 32'd14);
        chk("str_data", bus.st_val, 32'd7);

        clr(); bus.b_in = 1; bus.pc_in = 32'h100; bus.signed_imm_24_in = 24'hFFFFFE; go();
        chk("br_taken", 32'(bus.branch_taken), 32'h1);
        chk("br_addr", bus.branch_addr, 32'hF8);

        sub55(); go();
        add_ovf(1); freeze = 1; go();
        add_ovf(1); bus.val_rn_in = 32'h1234; bus.dest_in = 4'd9; freeze = 1; go();
        chk("frz_res", bus.alu_res, 32'h0);
        chk("frz_dest", 32'(bus.dest), 32'h3);
        chk("frz_sr", 32'(bus.status), 32'h6);
        add_ovf(1); freeze = 1; rst = 1; go();
        chk("frz_rst_dest", 32'(bus.dest), 32'hF);
        chk("frz_rst_sr", 32'(bus.status), 32'h0);
        chk("frz_rst_wb", 32'(bus.wb_en), 32'h0);

        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            bus.wb_en_in    = 1'($urandom_range(0, 1));
            bus.mem_r_en_in = ($urandom_range(0, 5) == 0);
            bus.mem_w_en_in = ($urandom_range(0, 5) == 0);
            bus.b_in        = 1'($urandom_range(0, 1));
            bus.s_in        = 1'($urandom_range(0, 1));
            bus.imm_in      = 1'($urandom_range(0, 1));
            bus.exe_cmd_in  = 4'($urandom_range(0, 15));
            bus.pc_in       = $urandom();
            bus.val_rn_in   = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom();
            bus.val_rm_in   = $urandom();
            bus.shift_operand_in = 12'($urandom());
            bus.signed_imm_24_in = 24'($urandom());
            bus.dest_in     = 4'($urandom());
            bus.sel_src1    = 2'($urandom_range(0, 3));
            bus.sel_src2    = 2'($urandom_range(0, 3));
            bus.mem_fwd_val = $urandom();
            bus.wb_fwd_val  = $urandom();
            go();
        end

        armed = 1'b0;
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
